// File: rtl/seven_seg_pkg.sv
// Shared constants and the ASCII-to-glyph table for the four-digit seven-segment driver.
// Glyphs are active-low, bit 0 = segment a through bit 6 = segment g.
package seven_seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Masks below are written active-high (1 = lit) in gfedcba order, then inverted.
  function automatic logic [6:0] ascii_to_seg(input logic [7:0] c);
    logic [7:0] u;
    logic [6:0] lit;
    logic       known;
    u     = c;
    lit   = 7'b0000000;
    known = 1'b1;
    if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
    case (u)
      "0": lit = 7'b0111111;
      "1": lit = 7'b0000110;
      "2": lit = 7'b1011011;
      "3": lit = 7'b1001111;
      "4": lit = 7'b1100110;
      "5": lit = 7'b1101101;
      "6": lit = 7'b1111101;
      "7": lit = 7'b0000111;
      "8": lit = 7'b1111111;
      "9": lit = 7'b1101111;
      "A": lit = 7'b1110111;
      "B": lit = 7'b1111100;
      "C": lit = 7'b0111001;
      "D": lit = 7'b1011110;
      "E": lit = 7'b1111001;
      "F": lit = 7'b1110001;
      "G": lit = 7'b0111101;
      "H": lit = 7'b1110110;
      "I": lit = 7'b0110000;
      "J": lit = 7'b0011110;
      "K": lit = 7'b1110101;
      "L": lit = 7'b0111000;
      "M": lit = 7'b0010101;
      "N": lit = 7'b1010100;
      "O": lit = 7'b1011100;
      "P": lit = 7'b1110011;
      "Q": lit = 7'b1100111;
      "R": lit = 7'b1010000;
      "S": lit = 7'b1101101;
      "T": lit = 7'b1111000;
      "U": lit = 7'b0111110;
      "V": lit = 7'b0011100;
      "W": lit = 7'b0101010;
      "X": lit = 7'b1110110;
      "Y": lit = 7'b1101110;
      "Z": lit = 7'b1011011;
      "-": lit = 7'b1000000;
      "_": lit = 7'b0001000;
      default: known = 1'b0;
    endcase
    return known ? ~lit : SEG_BLANK;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational ASCII to active-low seven-segment glyph decoder.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [7:0] i_char,
  output logic [6:0] o_seg
);

  assign o_seg = ascii_to_seg(i_char);

endmodule

// File: rtl/seven_seg.sv
// Four-digit multiplexed display driver: scan counter, character mux and registered
// anode/segment outputs for a common-anode display.
module seven_seg
  import seven_seg_pkg::*;
#(
  parameter int CNT_W = 18
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] display_0,
  input  logic [7:0] display_1,
  input  logic [7:0] display_2,
  input  logic [7:0] display_3,
  input  logic [1:0] decplace,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_seg;
  logic [3:0]       r_an;
  logic [1:0]       w_k;
  logic [7:0]       w_char;
  logic [6:0]       w_glyph;

  assign w_k = r_cnt[CNT_W-1 -: 2];

  always_comb begin
    w_char = display_0;
    case (w_k)
      2'd0: w_char = display_0;
      2'd1: w_char = display_1;
      2'd2: w_char = display_2;
      2'd3: w_char = display_3;
      default: w_char = display_0;
    endcase
  end

  seven_seg_decode u_decode (
    .i_char (w_char),
    .o_seg  (w_glyph)
  );

  // Outputs are loaded from the pre-increment count, so they lag the counter by one clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_an  <= 4'b1111;
      r_seg <= 8'hFF;
    end else begin
      r_cnt                <= r_cnt + 1'b1;
      r_an                 <= ~(4'b1000 >> w_k);
      r_seg[SEG_G:SEG_A]   <= w_glyph;
      r_seg[SEG_DP]        <= (w_k == decplace) ? 1'b0 : 1'b1;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign dp  = r_seg[SEG_DP];

endmodule

// File: tb/tb_seven_seg.sv
module tb_seven_seg;

  logic       clk;
  logic       rstn;
  logic [7:0] display_0, display_1, display_2, display_3;
  logic [1:0] decplace;
  logic [7:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  seven_seg #(.CNT_W(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .display_0 (display_0),
    .display_1 (display_1),
    .display_2 (display_2),
    .display_3 (display_3),
    .decplace  (decplace),
    .seg       (seg),
    .an        (an),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [3:0] an_exp  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [7:0] scan_seg[4] = '{8'hC0, 8'hF9, 8'h80, 8'h7F};
  logic [6:0] dig_exp [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0] let_exp [26] = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42,
                               7'h09, 7'h4F, 7'h61, 7'h0A, 7'h47, 7'h6A, 7'h2B,
                               7'h23, 7'h0C, 7'h18, 7'h2F, 7'h12, 7'h07, 7'h41,
                               7'h63, 7'h55, 7'h09, 7'h11, 7'h24};

  initial begin
    rstn = 1'b1;
    display_0 = "0"; display_1 = "1"; display_2 = "8"; display_3 = " ";
    decplace = 2'd3;

    // Reset held
    #1 rstn = 1'b0;
    #2;
    chk("rst_an", {4'h0, an}, 8'h0F);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_dp", {7'h0, dp}, 8'h01);

    // Scan order over two frames
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("scan_an", {4'h0, an}, {4'h0, an_exp[(i/4)%4]});
      chk("scan_seg", seg, scan_seg[(i/4)%4]);
      chk("scan_dp", {7'h0, dp}, ((i/4)%4 == 3) ? 8'h00 : 8'h01);
    end

    // Asynchronous reset mid-scan: visible before the next clock edge
    step(); step(); step();
    #2 rstn = 1'b0;
    #1;
    chk("midrst_an", {4'h0, an}, 8'h0F);
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_dp", {7'h0, dp}, 8'h01);

    // Decimal point on digit 2
    display_0 = "8"; display_1 = "8"; display_2 = "8"; display_3 = "8";
    decplace = 2'd2;
    restart();
    for (int i = 0; i < 16; i++) begin
      step();
      chk("dp_an", {4'h0, an}, {4'h0, an_exp[(i/4)%4]});
      chk("dp_seg", seg, ((i/4)%4 == 2) ? 8'h00 : 8'h80);
      chk("dp_dp", {7'h0, dp}, ((i/4)%4 == 2) ? 8'h00 : 8'h01);
    end

    // Decoder sweep on digit 0
    decplace = 2'd3;
    for (int i = 0; i < 10; i++) begin
      display_0 = 8'h30 + 8'(i);
      restart();
      step();
      chk("dec_digit", {1'b0, seg[6:0]}, {1'b0, dig_exp[i]});
    end
    for (int i = 0; i < 26; i++) begin
      display_0 = 8'h41 + 8'(i);
      restart();
      step();
      chk("dec_upper", {1'b0, seg[6:0]}, {1'b0, let_exp[i]});
      display_0 = 8'h61 + 8'(i);
      restart();
      step();
      chk("dec_lower", {1'b0, seg[6:0]}, {1'b0, let_exp[i]});
    end
    display_0 = "-"; restart(); step();
    chk("dec_dash", {1'b0, seg[6:0]}, 8'h3F);
    display_0 = "_"; restart(); step();
    chk("dec_under", {1'b0, seg[6:0]}, 8'h77);
    display_0 = " "; restart(); step();
    chk("dec_space", {1'b0, seg[6:0]}, 8'h7F);
    display_0 = 8'h01; restart(); step();
    chk("dec_ctrl", {1'b0, seg[6:0]}, 8'h7F);
    chk("dec_an", {4'h0, an}, 8'h07);

    // Live update of digit 1 while digit 0 is shown
    display_0 = "0"; display_1 = "1";
    restart();
    step();
    chk("live_d0", seg, 8'hC0);
    display_1 = "7";
    step(); step(); step();
    step();
    chk("live_an", {4'h0, an}, 8'h0B);
    chk("live_seg", {1'b0, seg[6:0]}, 8'h78);

    // Three full frames across counter wraps
    restart();
    for (int i = 0; i < 48; i++) begin
      step();
      chk("wrap_an", {4'h0, an}, {4'h0, an_exp[(i/4)%4]});
      chk("wrap_onehot", 8'($countones(~an)), 8'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
